dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001: Parameter LAT, default 2, number of dwait=1 cycles before a request completes (0 allowed).
REQ-002: Parameter DEPTH, default 256, number of 32-bit words in backing store (power of two).
REQ-003: CLK  input  1  clock; all state updates on rising edge.
REQ-004: nRST  input  1  reset, asynchronous, active-low.
REQ-005: dREN  input  1  data read request from dcache.
REQ-006: dWEN  input  1  data write request from dcache.
REQ-007: daddr  input  32  byte address; bits [1:0] ignored, word index = daddr[2 +: log2(DEPTH)].
REQ-008: dstore  input  32  write data.
REQ-009: dwait  output  1  1 = memory busy/not completing; 0 = request completes this cycle.
REQ-010: dload  output  32  read data, valid when dwait=0 and dREN=1.

Function
REQ-011: States: IDLE, BUSY; 2-bit-or-wider down-counter cnt; latched op (read/write) and word index.
REQ-012: Request = dREN | dWEN; when both are high, the request shall be treated as a write (write priority).
REQ-013: IDLE, no request: dwait=1, dload=32'hECE43700, stay IDLE.
REQ-014: IDLE, request, LAT=0: dwait=0 combinationally that cycle, access performed, stay IDLE.
REQ-015: IDLE, request, LAT>0: dwait=1, latch op and index, cnt<=LAT-1, go BUSY.
REQ-016: BUSY, request unchanged, cnt!=0: dwait=1, cnt<=cnt-1.
REQ-017: BUSY, request unchanged, cnt==0: dwait=0, access performed, go IDLE.
REQ-018: Completion timing: request first presented in cycle 0 -> dwait=1 in cycles 0..LAT-1, dwait=0 in cycle LAT.
REQ-019: Read access: dload = mem[index] combinationally in the completing cycle.
REQ-020: Write access: mem[index] <= dstore at the rising edge ending the completing cycle; dstore sampled then, not at request start.
REQ-021: dload while any request is pending but not completing shall equal mem[current daddr index] (don't-care to cache, but deterministic).
REQ-022: Abort: in BUSY, if request drops, op changes, or word index differs from latched value -> dwait=1, no memory update, go IDLE; a still-present new request restarts from IDLE next cycle with full LAT.
REQ-023: Back-to-back: after completion the block returns to IDLE; a request still held in the following cycle is a new request and incurs full LAT again.
REQ-024: Address wrap: indices alias modulo DEPTH; no error indication.
REQ-025: Read-after-write to same word in next transaction returns newly written data.

Reset
REQ-026: nRST low shall immediately force state=IDLE, cnt=0, latched op/index=0, dwait=1, and clear all DEPTH words to 32'h0.
REQ-027: Reset asserted mid-BUSY shall abort the transaction with no memory update; after release, a held request restarts with full LAT.
REQ-028: dload during reset follows REQ-013/REQ-021 with memory zeroed.

Verification
REQ-029: LAT=2; after reset, no request -> dwait=1, dload=32'hECE43700.
REQ-030: dWEN=1, daddr=0x4, dstore=32'hDEADBEEF held -> dwait=1,1,0 in cycles 0,1,2; then dREN=1, daddr=0x4 -> dwait=1,1,0, dload=32'hDEADBEEF in cycle 2.
REQ-031: dREN=1, daddr=0x8 (never written) -> dwait=0 in cycle 2 with dload=32'h0; daddr=0x404 after REQ-030 write -> dload=32'hDEADBEEF (wrap, DEPTH=256).
REQ-032: dREN=1 and dWEN=1, daddr=0xC, dstore=32'h12345678 -> completes as write; subsequent read of 0xC returns 32'h12345678.
REQ-033: Write to 0x10 started, daddr changed to 0x14 in cycle 1 -> no write to 0x10; 0x14 write completes in cycle 3 (restart, full LAT); read 0x10 returns 0.
REQ-034: nRST pulsed low in cycle 1 of a write to 0x18 -> dwait=1 immediately, 0x18 reads 0 after restart; LAT=0 build: read of 0x4 returns dwait=0 in cycle 0.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Behavioural data-memory responder for a dcache port. Each
//             request (read, write, or both = write) is held off with dwait=1
//             for LAT cycles. In the following cycle it completes with
//             dwait=0. A request that changes while it waits starts over.
//  Ports    : CLK     - clock, rising edge
//             nRST    - asynchronous active-low reset (also zeroes memory)
//             dREN    - read request
//             dWEN    - write request (wins over dREN)
//             daddr   - byte address, word index = daddr[2 +: log2(DEPTH)]
//             dstore  - write data, sampled at the edge ending completion
//             dwait   - 1 = busy / not completing, 0 = completes this cycle
//             dload   - read data (mem[current index] whenever a request
//                       is present, 32'hECE43700 when idle)
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 256
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload
);

    localparam int              c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              c_CW        = ($clog2(LAT + 1) > 2) ? $clog2(LAT + 1) : 2;
    localparam logic [c_CW-1:0] c_LOAD      = (LAT > 0) ? c_CW'(LAT - 1) : '0;
    localparam logic [31:0]     c_IDLE_LOAD = 32'hECE43700;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic            r_op;      // 1 = write
    logic [c_AW-1:0] r_idx;
    logic [31:0]     r_mem [DEPTH];

    logic            w_req;
    logic            w_op;
    logic [c_AW-1:0] w_idx;
    logic            w_same;
    logic            w_done;

    // Only the word-index bits of daddr address the store; the rest alias.
    logic            w_unused;
    assign w_unused = &{1'b0, daddr};

    assign w_req  = dREN | dWEN;
    assign w_op   = dWEN;
    assign w_idx  = daddr[2 +: c_AW];
    assign w_same = w_req && (w_op == r_op) && (w_idx == r_idx);

    // Completion is decided combinationally so that LAT=0 answers in the
    // same cycle. Holding reset low never lets a request complete.
    always_comb begin
        w_done = 1'b0;
        if (nRST && w_req) begin
            if (r_state == S_IDLE) begin
                w_done = (LAT == 0);
            end else begin
                w_done = w_same && (r_cnt == '0);
            end
        end
    end

    assign dwait = ~w_done;
    assign dload = w_req ? r_mem[w_idx] : c_IDLE_LOAD;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_idx   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_done && w_op) begin
                r_mem[w_idx] <= dstore;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req && (LAT != 0)) begin
                        r_state <= S_BUSY;
                        r_op    <= w_op;
                        r_idx   <= w_idx;
                        r_cnt   <= c_LOAD;
                    end
                end
                S_BUSY: begin
                    if (w_same) begin
                        if (r_cnt == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - c_CW'(1);
                        end
                    end else if (w_req) begin
                        // Abort with a different request already on the bus.
                        // This cycle is its first waiting cycle, so it is
                        // reloaded with the full latency instead of spending
                        // an extra cycle in IDLE.
                        r_op  <= w_op;
                        r_idx <= w_idx;
                        r_cnt <= c_LOAD;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder (LAT=2 and LAT=0 builds)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int          c_LAT  = 2;
    localparam logic [31:0] c_IDLE = 32'hECE43700;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dREN, dWEN;
    logic [31:0] daddr, dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        l0_ren, l0_wen;
    logic [31:0] l0_addr, l0_data;
    logic        l0_wait;
    logic [31:0] l0_load;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dmem_responder #(.LAT(c_LAT), .DEPTH(256)) u_dut (
        .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload)
    );

    dmem_responder #(.LAT(0), .DEPTH(256)) u_lat0 (
        .CLK(CLK), .nRST(nRST), .dREN(l0_ren), .dWEN(l0_wen),
        .daddr(l0_addr), .dstore(l0_data), .dwait(l0_wait), .dload(l0_load)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d);
        dREN = ren; dWEN = wen; daddr = a; dstore = d;
    endtask

    // Check the current cycle at the falling edge, then advance past the
    // next rising edge.
    task automatic cyc(input string name, input logic ew, input logic [31:0] el);
        @(negedge CLK);
        chk({name, ".dwait"}, {31'b0, dwait}, {31'b0, ew});
        chk({name, ".dload"}, dload, el);
        @(posedge CLK);
        #1;
    endtask

    // One full transaction held until completion: LAT waiting cycles, then done.
    task automatic xact(input string name, input logic ren, input logic wen,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] el);
        drive(ren, wen, a, d);
        for (int k = 0; k < c_LAT; k++) cyc(name, 1'b1, el);
        cyc(name, 1'b0, el);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // A request completes once it has been presented unchanged for LAT
    // earlier consecutive cycles; any change starts the count again.
    logic [31:0] m_mem [256];
    bit          m_active;
    bit          m_op;
    int          m_idx;
    int          m_waited;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        m_active = 0;
    endtask

    task automatic model_cycle(output logic ew, output logic [31:0] el);
        int  idx;
        bit  op;
        idx = int'(daddr[9:2]);
        op  = dWEN;
        if (!(dREN || dWEN)) begin
            ew = 1'b1; el = c_IDLE; m_active = 0;
        end else begin
            el = m_mem[idx];
            if (!m_active || op != m_op || idx != m_idx) begin
                m_active = 1; m_op = op; m_idx = idx; m_waited = 0;
            end
            if (m_waited == c_LAT) begin
                ew = 1'b0;
                if (op) m_mem[idx] = dstore;
                m_active = 0;
            end else begin
                ew = 1'b1;
                m_waited++;
            end
        end
    endtask

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ewait;
        logic [31:0] eload;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ren, logic wen, logic [31:0] a, logic [31:0] d,
                                logic ew, logic [31:0] el);
        vec_t v;
        v.ren = ren; v.wen = wen; v.addr = a; v.data = d; v.ewait = ew; v.eload = el;
        return v;
    endfunction

    initial begin
        logic        ew;
        logic [31:0] el;

        nRST = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        l0_ren = 1'b0; l0_wen = 1'b0; l0_addr = 32'h0; l0_data = 32'h0;

        @(negedge CLK);
        chk("reset.dwait", {31'b0, dwait}, 32'h1);
        chk("reset.dload", dload, c_IDLE);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // -------- table of directed vectors, one cycle each --------
        tbl.push_back(mk(0, 0, 32'h000, 32'h0,        1, c_IDLE));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 32'h004, 32'hDEADBEEF, k != 2, 32'h0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 32'h004, 32'h0,        k != 2, 32'hDEADBEEF));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 32'h008, 32'h0,        k != 2, 32'h0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 32'h404, 32'h0,        k != 2, 32'hDEADBEEF));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 1, 32'h00C, 32'h12345678, k != 2, 32'h0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 32'h00C, 32'h0,        k != 2, 32'h12345678));
        tbl.push_back(mk(0, 1, 32'h010, 32'hAAAA0010, 1, 32'h0));
        tbl.push_back(mk(0, 1, 32'h014, 32'h55550014, 1, 32'h0));
        tbl.push_back(mk(0, 1, 32'h014, 32'h55550014, 1, 32'h0));
        tbl.push_back(mk(0, 1, 32'h014, 32'h55550014, 0, 32'h0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(1, 0, 32'h010, 32'h0,        k != 2, 32'h0));
        // held read completes, then pays full latency again
        for (int k = 0; k < 6; k++) tbl.push_back(mk(1, 0, 32'h014, 32'h0,        (k % 3) != 2, 32'h55550014));
        tbl.push_back(mk(0, 0, 32'h014, 32'h0,        1, c_IDLE));

        foreach (tbl[i]) begin
            drive(tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].data);
            cyc($sformatf("tbl%0d", i), tbl[i].ewait, tbl[i].eload);
        end

        // -------- reset in the middle of a write, request dropped --------
        drive(0, 1, 32'h018, 32'h11110018);
        cyc("rst_mid.c0", 1'b1, 32'h0);
        nRST = 1'b0;
        #1;
        chk("rst_mid.dwait_immediate", {31'b0, dwait}, 32'h1);
        chk("rst_mid.dload_zeroed", dload, 32'h0);
        drive(0, 0, 32'h018, 32'h0);
        @(negedge CLK);
        chk("rst_mid.dload_idle", dload, c_IDLE);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        xact("rst_mid.rd18", 1, 0, 32'h018, 32'h0, 32'h0);
        xact("rst_mid.rd04_cleared", 1, 0, 32'h004, 32'h0, 32'h0);

        // -------- reset mid-write with the request held across it --------
        drive(0, 1, 32'h01C, 32'h2222001C);
        cyc("rst_hold.c0", 1'b1, 32'h0);
        nRST = 1'b0;
        #1;
        chk("rst_hold.dwait_immediate", {31'b0, dwait}, 32'h1);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        xact("rst_hold.restart", 0, 1, 32'h01C, 32'h2222001C, 32'h0);
        xact("rst_hold.rd1c", 1, 0, 32'h01C, 32'h0, 32'h2222001C);
        drive(0, 0, 32'h0, 32'h0);

        // -------- LAT=0 build --------
        l0_ren = 1'b1; l0_wen = 1'b0; l0_addr = 32'h004;
        @(negedge CLK);
        chk("lat0.rd.dwait", {31'b0, l0_wait}, 32'h0);
        chk("lat0.rd.dload", l0_load, 32'h0);
        @(posedge CLK); #1;
        l0_ren = 1'b0; l0_wen = 1'b1; l0_data = 32'hCAFE0004;
        @(negedge CLK);
        chk("lat0.wr.dwait", {31'b0, l0_wait}, 32'h0);
        @(posedge CLK); #1;
        l0_ren = 1'b1; l0_wen = 1'b0;
        @(negedge CLK);
        chk("lat0.raw.dwait", {31'b0, l0_wait}, 32'h0);
        chk("lat0.raw.dload", l0_load, 32'hCAFE0004);
        @(posedge CLK); #1;
        l0_ren = 1'b0;
        @(negedge CLK);
        chk("lat0.idle.dwait", {31'b0, l0_wait}, 32'h1);
        chk("lat0.idle.dload", l0_load, c_IDLE);
        @(posedge CLK); #1;

        // -------- randomized run against the reference model --------
        do_reset();
        model_clear();
        for (int n = 0; n < 800; n++) begin
            if (n == 0 || $urandom_range(0, 99) < 30) begin
                case ($urandom_range(0, 3))
                    0: begin dREN = 0; dWEN = 0; end
                    1: begin dREN = 1; dWEN = 0; end
                    2: begin dREN = 0; dWEN = 1; end
                    default: begin dREN = 1; dWEN = 1; end
                endcase
                daddr = {22'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 3'b0, 2'($urandom)};
            end
            dstore = $urandom;
            @(negedge CLK);
            model_cycle(ew, el);
            chk($sformatf("rnd%0d.dwait", n), {31'b0, dwait}, {31'b0, ew});
            chk($sformatf("rnd%0d.dload", n), dload, el);
            @(posedge CLK);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
